// File: rtl/morse_shifter_if.sv
// Bundle of the letter request and Morse output signals between a controller and morse_shifter.
// Handshake: start is a one-cycle request honoured only while busy=0; done pulses once when the letter ends.
interface morse_shifter_if;
  logic       tick;
  logic       start;
  logic [2:0] letter;
  logic       led;
  logic       busy;
  logic       done;
  logic       fsm_state;

  modport master (
    output tick, start, letter,
    input  led, busy, done, fsm_state
  );

  modport slave (
    input  tick, start, letter,
    output led, busy, done, fsm_state
  );
endinterface

// File: rtl/morse_shifter.sv
// Plays one Morse letter (S..Z) on led, one bit per tick, followed by an off/terminator tick and a done pulse.
// fsm_state exposes the FSM (0 = IDLE, 1 = SHIFT) for checkers.
module morse_shifter #(
  parameter int PATTERN_W = 14
) (
  input logic            CLOCK_50,
  input logic            reset_n,
  morse_shifter_if.slave bus
);

  localparam int CW = $clog2(PATTERN_W + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 state, state_n;
  logic [PATTERN_W-1:0]   shreg, shreg_n;
  logic [CW-1:0]          remaining, remaining_n;
  logic                   led_q, led_n;
  logic                   done_q, done_n;

  // Table patterns are 14 bits left-justified; widen by padding zeros on the right.
  function automatic logic [PATTERN_W-1:0] pattern_of(input logic [2:0] l);
    logic [13:0]          raw;
    logic [PATTERN_W-1:0] wide;
    case (l)
      3'b000:  raw = 14'b10101000000000;
      3'b001:  raw = 14'b11100000000000;
      3'b010:  raw = 14'b10101110000000;
      3'b011:  raw = 14'b10101011100000;
      3'b100:  raw = 14'b10111011100000;
      3'b101:  raw = 14'b11101010111000;
      3'b110:  raw = 14'b11101011101110;
      default: raw = 14'b11101110101000;
    endcase
    wide = '0;
    wide[PATTERN_W-1 -: 14] = raw;
    return wide;
  endfunction

  function automatic logic [CW-1:0] length_of(input logic [2:0] l);
    case (l)
      3'b000:  return CW'(6);
      3'b001:  return CW'(4);
      3'b010:  return CW'(8);
      3'b011:  return CW'(10);
      3'b100:  return CW'(10);
      3'b101:  return CW'(12);
      3'b110:  return CW'(14);
      default: return CW'(12);
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      remaining <= '0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      remaining <= remaining_n;
      led_q     <= led_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    remaining_n = remaining;
    led_n       = led_q;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        // A tick arriving with start only loads; no bit is consumed here.
        led_n = 1'b0;
        if (bus.start) begin
          shreg_n     = pattern_of(bus.letter);
          remaining_n = length_of(bus.letter);
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.tick) begin
          if (remaining != '0) begin
            led_n       = shreg[PATTERN_W-1];
            shreg_n     = {shreg[PATTERN_W-2:0], 1'b0};
            remaining_n = remaining - CW'(1);
          end else begin
            led_n   = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.led       = led_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state == SHIFT);
  assign bus.fsm_state = (state == SHIFT);

endmodule

// File: tb/tb_morse_shifter.sv
// Directed bench for morse_shifter: table of letters with hand-written bit patterns,
// plus sequences for ignored restarts and asynchronous reset mid-letter.
module tb_morse_shifter;

  logic clk;
  logic rst_n;

  morse_shifter_if bus ();

  morse_shifter #(.PATTERN_W(14)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  letter;
    int          len;
    logic [13:0] bits;
    bit          tick_with_start;
  } vec_t;

  vec_t vecs[8];
  logic [0:0] exp_q[$];
  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays a letter; leaves the bench in the cycle where done is high.
  task automatic play(input logic [2:0] ltr, input int len, input logic [13:0] bits,
                      input bit tick_with_start, input int intrude_tick);
    logic cur;
    logic exp;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(bits[13-i]);
    bus.letter = ltr;
    bus.start  = 1'b1;
    bus.tick   = tick_with_start;
    step();
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    check("start_busy", 16'(bus.busy), 16'd1);
    check("start_led", 16'(bus.led), 16'd0);
    check("start_done", 16'(bus.done), 16'd0);
    cur = 1'b0;
    for (int t = 1; t <= len + 1; t++) begin
      repeat (3) step();
      check("hold_led", 16'(bus.led), 16'(cur));
      check("hold_busy", 16'(bus.busy), 16'd1);
      bus.tick = 1'b1;
      if (t == intrude_tick) begin
        bus.start  = 1'b1;
        bus.letter = 3'b000;
      end
      step();
      bus.tick   = 1'b0;
      bus.start  = 1'b0;
      bus.letter = ltr;
      if (t <= len) begin
        if (exp_q.size() == 0) begin
          check("queue_empty", 16'd1, 16'd0);
          exp = 1'b0;
        end else begin
          exp = exp_q.pop_front();
        end
        check("tick_led", 16'(bus.led), 16'(exp));
        check("tick_busy", 16'(bus.busy), 16'd1);
        check("tick_done", 16'(bus.done), 16'd0);
        cur = exp;
      end else begin
        check("end_led", 16'(bus.led), 16'd0);
        check("end_done", 16'(bus.done), 16'd1);
        check("end_busy", 16'(bus.busy), 16'd0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{3'b001, 4,  14'b11100000000000, 1'b0};  // T
    vecs[1] = '{3'b000, 6,  14'b10101000000000, 1'b0};  // S
    vecs[2] = '{3'b110, 14, 14'b11101011101110, 1'b0};  // Y, full width
    vecs[3] = '{3'b010, 8,  14'b10101110000000, 1'b1};  // U, tick with start
    vecs[4] = '{3'b011, 10, 14'b10101011100000, 1'b0};  // V
    vecs[5] = '{3'b100, 10, 14'b10111011100000, 1'b1};  // W, tick with start
    vecs[6] = '{3'b101, 12, 14'b11101010111000, 1'b0};  // X
    vecs[7] = '{3'b111, 12, 14'b11101110101000, 1'b0};  // Z

    n_vec = 0;
    n_err = 0;
    rst_n      = 1'b0;
    bus.tick   = 1'b0;
    bus.start  = 1'b0;
    bus.letter = 3'b000;
    #1;
    check("rst_led", 16'(bus.led), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_done", 16'(bus.done), 16'd0);
    check("rst_state", 16'(bus.fsm_state), 16'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // Ticks while idle are ignored
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check("idle_tick_led", 16'(bus.led), 16'd0);
    check("idle_tick_busy", 16'(bus.busy), 16'd0);
    step();

    // Back-to-back plays: each new start lands in the done cycle of the previous letter
    for (int v = 0; v < 8; v++)
      play(vecs[v].letter, vecs[v].len, vecs[v].bits, vecs[v].tick_with_start, 0);
    step();
    check("done_pulse_width", 16'(bus.done), 16'd0);

    // Second start at tick 3 of Z with letter S is ignored
    play(3'b111, 12, 14'b11101110101000, 1'b0, 3);
    step();
    check("after_z_done", 16'(bus.done), 16'd0);
    check("after_z_busy", 16'(bus.busy), 16'd0);

    // Asynchronous reset at tick 5 of X
    bus.letter = 3'b101;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      repeat (3) step();
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
    end
    check("x_tick5_led", 16'(bus.led), 16'd1);
    check("x_tick5_busy", 16'(bus.busy), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", 16'(bus.led), 16'd0);
    check("async_busy", 16'(bus.busy), 16'd0);
    check("async_done", 16'(bus.done), 16'd0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.tick = (c % 4 == 3);
      step();
      check("post_rst_done", 16'(bus.done), 16'd0);
      check("post_rst_busy", 16'(bus.busy), 16'd0);
      check("post_rst_led", 16'(bus.led), 16'd0);
    end
    bus.tick = 1'b0;
    play(3'b001, 4, 14'b11100000000000, 1'b0, 0);
    step();
    check("final_done", 16'(bus.done), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/morse_shifter.md
MORSE_SHIFTER -- requirements
Module: morse_shifter

Interface
REQ-001 The block SHALL have parameter PATTERN_W, default 14, meaning the width of the pattern shift register and the maximum symbol length in ticks.
REQ-002 The block SHALL have port CLOCK_50, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port tick, input, 1 bit, a one-cycle enable pulse from the rate divider that marks one 0.5 s Morse time unit.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle start request that is already debounced and edge-detected upstream.
REQ-006 The block SHALL have port letter, input, 3 bits, the letter select: 000=S, 001=T, 010=U, 011=V, 100=W, 101=X, 110=Y, 111=Z.
REQ-007 The block SHALL have port led, output, 1 bit, the registered Morse output (1 = lamp on).
REQ-008 The block SHALL have port busy, output, 1 bit, which is high while a letter is being played.
REQ-009 The block SHALL have port done, output, 1 bit, a registered one-cycle pulse at the end of a letter.

Function
REQ-010 Encoding SHALL be: dot = 10, dash = 1110, sent MSB first and left-justified in PATTERN_W bits.
REQ-011 The pattern table SHALL be (bits, length): S 101010/6; T 1110/4; U 10101110/8; V 1010101110/10; W 1011101110/10; X 111010101110/12; Y 11101011101110/14; Z 111011101010/12.
REQ-012 The FSM SHALL have two states, IDLE and SHIFT; busy SHALL equal (state == SHIFT).
REQ-013 In IDLE, when start=1, the block SHALL load the shift register with the pattern for letter, load the remaining count with its length, and enter SHIFT; letter is sampled only in that cycle.
REQ-014 In IDLE, when start=0, the block SHALL hold led=0 and ignore tick.
REQ-015 If start and tick are both 1 in the same IDLE cycle, the block SHALL only load; that tick SHALL NOT consume a bit.
REQ-016 In SHIFT, on tick with remaining>0, the block SHALL set led to the shift-register MSB, shift left by one with zero fill, and decrement remaining by one.
REQ-017 In SHIFT, on tick with remaining==0, the block SHALL set led=0, drive done=1 for exactly the next cycle, and return to IDLE.
REQ-018 In SHIFT, without tick, the block SHALL hold all state and led.
REQ-019 The first bit SHALL appear on led at the first tick strictly after the start cycle.
REQ-020 Total occupancy SHALL be length+1 ticks; the final tick is the off/terminator tick.
REQ-021 A start received while in SHIFT SHALL be ignored and SHALL NOT be queued.
REQ-022 done and start in the same cycle: because the state is IDLE once done is visible, the start SHALL be accepted.
REQ-023 The remaining counter SHALL be ceil(log2(PATTERN_W+1)) bits wide and SHALL never wrap below 0.

Reset
REQ-024 When reset_n=0, the block SHALL immediately, without waiting for a clock, force state=IDLE, led=0, done=0, busy=0, shift register=0, and remaining=0.
REQ-025 Reset asserted mid-letter SHALL abort the letter with no done pulse; after release, the block SHALL wait for a new start.
REQ-026 After reset release, the block SHALL require no warm-up cycles.

Verification
REQ-027 Reset, then letter=001 (T), one start pulse, tick every 4 clocks -> led 1,1,1,0 at ticks 1-4; tick 5 -> led=0 and done high for 1 cycle; busy high from the cycle after start until done.
REQ-028 letter=000 (S) -> led across ticks 1-6 = 1,0,1,0,1,0; done after tick 7.
REQ-029 letter=110 (Y) -> 14-bit sequence 11101011101110 on led, then done; this checks full PATTERN_W length.
REQ-030 start and tick asserted in the same cycle while IDLE -> no bit consumed; the first led bit appears at the following tick.
REQ-031 letter=111 (Z) playing, second start at tick 3 with letter=000 -> ignored; the full Z pattern completes unchanged.
REQ-032 reset_n pulsed low between clock edges at tick 5 of X -> led=0 and busy=0 immediately, no done pulse; a new start with T then plays correctly.
